// File: rtl/cpu_reg_file_mp.sv
// -----------------------------------------------------------------------------
// cpu_reg_file_mp
//
// Multi-port CPU register file. It has BITS-wide registers, SIZE entries,
// READ_PORTS combinational read ports and two prioritised write ports, and a
// write on either port is visible on a read port in the same cycle.
// Contents are zeroed by a sequential clear engine after reset or when
// requested. The engine clears one entry per cycle.
//
// Optional feature (compile-time macro):
//   CPU_REG_FILE_ZERO_REG_EN - register 0 reads as zero and ignores writes.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   en                          block enable; low => reads hi-Z, writes dropped
//   clear                       request a full clear (sampled when READY)
//   busy                        high while the clear engine runs
//   wr_1/addr_write_1/data_write_1  write port 1 (high priority)
//   wr_2/addr_write_2/data_write_2  write port 2 (low priority)
//   addr_read                   packed read addresses, port k at [k*ADDRESS_BITS +: ADDRESS_BITS]
//   data_read                   packed read data, port k at [k*BITS +: BITS]
// -----------------------------------------------------------------------------
module cpu_reg_file_mp #(
  parameter int BITS       = 8,
  parameter int SIZE       = 16,
  parameter int READ_PORTS = 2,
  localparam int ADDRESS_BITS = $clog2(SIZE)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               clear,
  output logic                               busy,
  input  logic                               wr_1,
  input  logic [ADDRESS_BITS-1:0]            addr_write_1,
  input  logic [BITS-1:0]                    data_write_1,
  input  logic                               wr_2,
  input  logic [ADDRESS_BITS-1:0]            addr_write_2,
  input  logic [BITS-1:0]                    data_write_2,
  input  logic [READ_PORTS*ADDRESS_BITS-1:0] addr_read,
  output logic [READ_PORTS*BITS-1:0]         data_read
);

`ifdef CPU_REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [ADDRESS_BITS-1:0] LAST_IDX = ADDRESS_BITS'(SIZE - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                  state;
  logic [ADDRESS_BITS-1:0] clear_idx;
  logic [BITS-1:0]         mem [SIZE];

  logic wr_1_ok;
  logic wr_2_ok;
  logic [READ_PORTS*BITS-1:0] rd_all;

  // ---------------------------------------------------------------------------
  // Clear engine. busy is registered and tracks state == CLEAR, so it drops
  // on the same edge that writes the last entry.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clear_idx <= '0;
      busy      <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clear_idx <= clear_idx + 1'b1;
          if (clear_idx == LAST_IDX) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (clear) begin
            state     <= CLEAR;
            clear_idx <= '0;
            busy      <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write qualification. Port 2 yields to port 1 on an address collision even
  // when port 1's write is itself discarded (zero register), so a collision
  // never lets the low-priority data through.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_1_ok = en && !busy && wr_1 && !(ZERO_REG && addr_write_1 == '0);
    wr_2_ok = en && !busy && wr_2 && !(ZERO_REG && addr_write_2 == '0)
              && !(wr_1 && addr_write_2 == addr_write_1);
  end

  // NOTE: the storage array has no reset; it is zeroed by the clear engine one
  // entry per cycle so it can map onto plain RAM/flop arrays without a reset
  // tree.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clear_idx] <= '0;
    end else begin
      if (wr_1_ok) mem[addr_write_1] <= data_write_1;
      if (wr_2_ok) mem[addr_write_2] <= data_write_2;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports with same-cycle bypass; port 1 data wins over port 2 data.
  // ---------------------------------------------------------------------------
  // NOTE: rd_all gets a full default before the loop, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rd_all = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      logic [ADDRESS_BITS-1:0] a;
      a = addr_read[k*ADDRESS_BITS +: ADDRESS_BITS];
      if (busy || (ZERO_REG && a == '0))
        rd_all[k*BITS +: BITS] = '0;
      else if (wr_1 && addr_write_1 == a)
        rd_all[k*BITS +: BITS] = data_write_1;
      else if (wr_2 && addr_write_2 == a)
        rd_all[k*BITS +: BITS] = data_write_2;
      else
        rd_all[k*BITS +: BITS] = mem[a];
    end
  end

  // The read bus is released when the block is disabled so it can be shared.
  assign data_read = en ? rd_all : {(READ_PORTS*BITS){1'bz}};

endmodule
